mod_inverse: RTL and testbench

//  Iterative modular inverse over Z_q (q = 12289): inv_out = a_in^(q-2) mod q (Fermat).

---
 rtl/mod_inverse_if.sv | 14 +
 rtl/mod_inverse.sv | 161 ++++++++++++++++
 tb/tb_mod_inverse.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mod_inverse_if.sv
// Start/ready/done handshake bundle for the modular inverse unit.
interface mod_inverse_if #(
  parameter int DATA_W = 14
);
  logic              start;
  logic [DATA_W-1:0] a_in;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] inv_out;
  logic              err;

  modport master (output start, a_in, input ready, done, inv_out, err);
  modport slave  (input start, a_in, output ready, done, inv_out, err);
endinterface

// File: rtl/mod_inverse.sv
// Modular inverse over Z_q via Fermat (a^(q-2)), left-to-right square-and-multiply
// driving one 4-stage Barrett multiplier serially.
module mod_inverse #(
  parameter int DATA_W = 14,
  parameter int Q      = 12289,
  parameter int EXP    = 12287
) (
  input logic          clk,
  input logic          rst,
  mod_inverse_if.slave bus
);

  localparam int K       = 2 * DATA_W;
  localparam int M_W     = DATA_W + 1;
  localparam int QM_W    = K + M_W;
  localparam int EXP_LEN = $clog2(EXP + 1);
  localparam int IDX_W   = $clog2(EXP_LEN);

  localparam longint unsigned BM_L = (64'd1 << K) / 64'(Q);
  localparam logic [M_W-1:0]     BM    = M_W'(BM_L);
  localparam logic [DATA_W-1:0]  Q_D   = DATA_W'(Q);
  localparam logic [DATA_W:0]    Q_W1  = {1'b0, Q_D};
  localparam logic [EXP_LEN-1:0] EXP_V = EXP_LEN'(EXP);

  typedef enum logic [2:0] {IDLE, REJ, SQR, WAIT_S, MUL, WAIT_M, FIN, DONE} state_t;

  // Barrett leaves r in [0, 2q); one conditional subtract completes the reduction.
  function automatic logic [DATA_W-1:0] reduce_once(input logic [DATA_W:0] r);
    logic [DATA_W:0] s;
    s = (r >= Q_W1) ? (r - Q_W1) : r;
    return DATA_W'(s);
  endfunction

  state_t              state;
  logic                rdy;
  logic                dn;
  logic                err_flag;
  logic                bad;
  logic [DATA_W-1:0]   result;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   a_reg;
  logic [IDX_W-1:0]    idx;

  logic [DATA_W-1:0]   opa_p0, opb_p0;
  logic                vld_p0, vld_p1, vld_p2, vld_p3;
  logic [K-1:0]        prod_p1, prod_p2;
  logic [DATA_W-1:0]   qhat_p2;
  logic [DATA_W-1:0]   res_p3;
  logic [QM_W-1:0]     qm_p1;
  logic [DATA_W:0]     r_p2;

  assign bus.ready   = rdy;
  assign bus.done    = dn;
  assign bus.inv_out = result;
  assign bus.err     = err_flag;

  assign qm_p1 = QM_W'(prod_p1) * QM_W'(BM);
  assign r_p2  = (DATA_W + 1)'(prod_p2) - ({1'b0, qhat_p2} * Q_W1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy      <= 1'b1;
      dn       <= 1'b0;
      err_flag <= 1'b0;
      result   <= '0;
      bad      <= 1'b0;
      acc      <= '0;
      a_reg    <= '0;
      idx      <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      dn     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rdy   <= 1'b0;
            a_reg <= bus.a_in;
            idx   <= IDX_W'(EXP_LEN - 2);
            if (bus.a_in == '0 || bus.a_in >= Q_D) begin
              bad   <= 1'b1;
              acc   <= '0;
              state <= REJ;
            end else begin
              bad   <= 1'b0;
              acc   <= bus.a_in;
              state <= SQR;
            end
          end
        end
        REJ: state <= FIN;
        SQR: begin
          opa_p0 <= acc;
          opb_p0 <= acc;
          vld_p0 <= 1'b1;
          state  <= WAIT_S;
        end
        WAIT_S: begin
          if (vld_p3) begin
            acc <= res_p3;
            if (EXP_V[idx]) begin
              state <= MUL;
            end else if (idx == '0) begin
              state <= FIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQR;
            end
          end
        end
        MUL: begin
          opa_p0 <= acc;
          opb_p0 <= a_reg;
          vld_p0 <= 1'b1;
          state  <= WAIT_M;
        end
        WAIT_M: begin
          if (vld_p3) begin
            acc <= res_p3;
            if (idx == '0) begin
              state <= FIN;
            end else begin
              idx   <= idx - 1'b1;
              state <= SQR;
            end
          end
        end
        FIN: begin
          result   <= acc;
          err_flag <= bad;
          dn       <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0 -> p1: full product; p1 -> p2: Barrett quotient estimate; p2 -> p3: reduced result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
    prod_p1 <= K'(opa_p0) * K'(opb_p0);
    prod_p2 <= prod_p1;
    qhat_p2 <= DATA_W'(qm_p1 >> K);
    res_p3  <= reduce_once(r_p2);
  end

endmodule

// File: tb/tb_mod_inverse.sv
// Directed bench for mod_inverse: vector table plus busy-start, reset-abort and back-to-back sequences.
module tb_mod_inverse;
  localparam int     DW = 14;
  localparam longint QV = 12289;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_inverse_if #(.DATA_W(DW)) bus ();
  mod_inverse dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] a;
    int            inv;
    bit            err;
    int            lat;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [DW-1:0] a, output int inv, output bit e,
                       output int lat, output int rdy_hi);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    @(negedge clk);
    bus.start = 1'b0;
    lat    = 0;
    rdy_hi = 0;
    while (bus.done !== 1'b1 && lat < 300) begin
      if (bus.ready) rdy_hi++;
      @(negedge clk);
      lat++;
    end
    inv = int'(bus.inv_out);
    e   = bus.err;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int inv, lat, rdy_hi, ndone, first, res;
    bit e;
    int vals[$];
    int n_vals, nacc, last_acc, t;
    longint cur_a;
    bit prev_take;

    vecs[0] = '{14'd1,     1,     1'b0, 126};
    vecs[1] = '{14'd2,     6145,  1'b0, 126};
    vecs[2] = '{14'd3,     8193,  1'b0, 126};
    vecs[3] = '{14'd12288, 12288, 1'b0, 126};
    vecs[4] = '{14'd0,     0,     1'b1, 2};
    vecs[5] = '{14'd12289, 0,     1'b1, 2};
    vecs[6] = '{14'd5,     2458,  1'b0, 126};
    vecs[7] = '{14'd16383, 0,     1'b1, 2};
    vecs[8] = '{14'd4,     9217,  1'b0, 126};
    vecs[9] = '{14'd7,     8778,  1'b0, 126};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.ready, 1);
    chk("reset_done", bus.done, 0);
    chk("reset_inv", bus.inv_out, 0);
    chk("reset_err", bus.err, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, inv, e, lat, rdy_hi);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_inv", i), inv, vecs[i].inv);
      chk($sformatf("vec%0d_err", i), e, vecs[i].err);
      chk($sformatf("vec%0d_ready_busy", i), rdy_hi, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), bus.done, 0);
      chk($sformatf("vec%0d_ready_back", i), bus.ready, 1);
    end

    // start pulses while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 14'd2;
    ndone = 0;
    first = -1;
    res   = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      bus.start = (k == 10 || k == 60);
      bus.a_in  = (k == 10 || k == 60) ? 14'd7 : 14'd2;
      if (bus.done) begin
        ndone++;
        if (first < 0) first = k;
        res = int'(bus.inv_out);
      end
    end
    bus.start = 1'b0;
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_latency", first, 126);
    chk("busy_start_inv", res, 6145);

    // reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 14'd3;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_inv", bus.inv_out, 0);
    ndone = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(14'd3, inv, e, lat, rdy_hi);
    chk("after_abort_latency", lat, 126);
    chk("after_abort_inv", inv, 8193);
    chk("after_abort_err", e, 0);
    @(negedge clk);

    // back-to-back with start held high
    for (int a = 1; a <= 80; a++) vals.push_back(a);
    for (int a = 12209; a <= 12288; a++) vals.push_back(a);
    n_vals   = vals.size();
    nacc     = 0;
    ndone    = 0;
    last_acc = -1;
    t        = 0;
    cur_a    = 0;
    @(negedge clk);
    bus.a_in  = DW'(vals[0]);
    bus.start = 1'b1;
    prev_take = bus.ready && bus.start;
    while (ndone < n_vals && t < n_vals * 128 + 400) begin
      @(negedge clk);
      t++;
      if (prev_take) begin
        if (last_acc >= 0) chk($sformatf("b2b_period_a%0d", vals[nacc]), t - last_acc, 128);
        last_acc = t;
        cur_a    = longint'(vals[nacc]);
        nacc++;
        if (nacc < n_vals) bus.a_in = DW'(vals[nacc]);
        else bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        chk($sformatf("b2b_latency_a%0d", cur_a), t - last_acc, 126);
        chk($sformatf("b2b_product_a%0d", cur_a), (cur_a * longint'(bus.inv_out)) % QV, 1);
        chk($sformatf("b2b_err_a%0d", cur_a), bus.err, 0);
      end
      prev_take = bus.ready && bus.start;
    end
    bus.start = 1'b0;
    chk("b2b_done_count", ndone, n_vals);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
